neuron_mac_sequencer: RTL and testbench
=======================================

# neuron_mac_sequencer

Sequencing controller for one neuron of a fully connected layer. On `start` it walks the neuron's weight memory and the layer's input-activation buffer in lockstep, issuing one read per cycle to each. It multiply-accumulates the returned signed fixed-point pairs and presents the full-precision sum plus a saturated, rescaled `DATA_WIDTH` result to the downstream activation stage through a valid/ready handshake. It sits between the per-neuron weight ROM, the shared input buffer and the activation/next-layer logic.

## Interface
- `NUM_INPUTS`, 30, number of weights/inputs per neuron (≥2)
- `DATA_WIDTH`, 16, two's-complement width of weights, inputs and `res_q`
- `ADDR_WIDTH`, $clog2(NUM_INPUTS), read-address width
- `FRAC_BITS`, 8, fractional bits of weight and input format
- `ACC_WIDTH`, 2*DATA_WIDTH+$clog2(NUM_INPUTS), accumulator width
- `clk` in 1 — sole clock, rising edge
- `rst` in 1 — synchronous, active-high reset
- `start` in 1 — begin one neuron evaluation; sampled only in IDLE
- `busy` out 1 — evaluation in progress
- `w_ren` out 1 — weight memory read enable
- `w_radd` out ADDR_WIDTH — weight read address
- `w_rdata` in DATA_WIDTH — weight data, valid 1 cycle after `w_ren`
- `x_ren` out 1 — input buffer read enable
- `x_radd` out ADDR_WIDTH — input read address
- `x_rdata` in DATA_WIDTH — input data, valid 1 cycle after `x_ren`
- `acc_out` out ACC_WIDTH — full-precision signed sum
- `res_q` out DATA_WIDTH — `acc_out >>> FRAC_BITS`, saturated to DATA_WIDTH
- `out_valid` out 1 — result valid
- `out_ready` in 1 — downstream accepts result
- `done` out 1 — single-cycle pulse on result handshake

## Operation
- The FSM has four states: IDLE, FETCH, DRAIN, HOLD.
- **IDLE → FETCH:** taken on `start`=1. The accumulator, address counter and data-valid pipe bit are cleared.
- **FETCH:**
  - `w_ren`=`x_ren`=1 and `w_radd`=`x_radd`=counter, running 0..NUM_INPUTS-1, one per cycle.
  - After issuing NUM_INPUTS-1, go to DRAIN.
  - Addresses never exceed NUM_INPUTS-1; there is no wrap.
- **DRAIN:** reads are deasserted and the last returned pair is accumulated. Then go to HOLD.
- **HOLD:**
  - `out_valid`=1.
  - `acc_out` and `res_q` are stable until `out_ready`=1.
  - On handshake: `done` pulses for 1 cycle and the FSM returns to IDLE.
- A 1-bit pipe register delays `w_ren` by one cycle. When it is set, `acc <= acc + $signed(w_rdata)*$signed(x_rdata)`, with sign extension to ACC_WIDTH.
- Overflow of the accumulator is impossible by construction.
- `res_q` is formed from `acc_out` arithmetic-shifted right by FRAC_BITS (truncation toward −∞):
  - above 2^(DATA_WIDTH-1)-1 → clamp to 0x7FFF (default width);
  - below −2^(DATA_WIDTH-1) → clamp to 0x8000.
- `start` outside IDLE is ignored, including in the handshake cycle.
- `busy`=1 in FETCH, DRAIN and HOLD.
- Address ports drive 0 whenever their read enable is 0.

## Timing
- **Reset values:** state IDLE; `busy`, `w_ren`, `x_ren`, `out_valid`, `done` = 0; `w_radd`, `x_radd`, `acc_out`, `res_q` = 0.
- **Reset mid-operation:** `rst` wins over all other inputs in that cycle. Outputs take reset values on the next edge and the partial sum is discarded.
- **Read schedule:** with `start` sampled at edge of cycle T, reads of address k are issued in cycle T+1+k.
- **Result latency:** `out_valid` rises in cycle T+NUM_INPUTS+2 (32 cycles for the default).
- **Downstream ready:** with `out_ready` held at 1, `done` coincides with the first `out_valid` cycle. The next `start` is accepted one cycle later, giving a minimum period of NUM_INPUTS+3 cycles.
- **Back-pressure:** `out_valid` stays high until `out_ready`=1.
- **Result registers:** `acc_out` and `res_q` are registered and change only during FETCH/DRAIN accumulation and on clear.

## Test plan
- **Reset state:** reset, then idle 5 cycles → all outputs 0, no read enables.
- **Unity sum:** all weights 0x0100 (1.0) and all inputs 0x0100, start → reads 0..29 on consecutive cycles; `out_valid` at T+32; `acc_out`=30·65536=1966080; `res_q`=0x1E00 (30.0).
- **Alternating signs:**
  - weights alternate 0x0100/0xFF00 (±1.0), inputs 0x0200, `out_ready` held 1;
  - expect `acc_out`=0, `res_q`=0, `done` with `out_valid` in the same cycle.
- **Saturation and back-pressure:**
  - all weights 0x7FFF and inputs 0x7FFF;
  - `res_q` = 0x7FFF;
  - with `out_ready`=0 for 10 cycles, outputs hold and `done` stays 0 until `out_ready` rises.
  - Mirror case: weights 0x8000, inputs 0x7FFF → `res_q`=0x8000.
- **Ignored start:** pulse `start` during FETCH and HOLD → no restart, addresses continue monotonically, one `done` only.
- **Reset mid-operation:** assert `rst` at address 12 → the next cycle is IDLE with zeroed outputs. A following start yields the correct full sum of a fresh evaluation.

Source files
------------

// File: rtl/neuron_mac_sequencer.sv
// rtl/neuron_mac_sequencer.sv - read sequencer and signed MAC for one fully connected neuron
module neuron_mac_sequencer #(
    parameter int NUM_INPUTS = 30,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = $clog2(NUM_INPUTS),
    parameter int FRAC_BITS  = 8,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(NUM_INPUTS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  w_ren,
    output logic [ADDR_WIDTH-1:0] w_radd,
    input  logic [DATA_WIDTH-1:0] w_rdata,
    output logic                  x_ren,
    output logic [ADDR_WIDTH-1:0] x_radd,
    input  logic [DATA_WIDTH-1:0] x_rdata,
    output logic [ACC_WIDTH-1:0]  acc_out,
    output logic [DATA_WIDTH-1:0] res_q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_INPUTS - 1);
    localparam int PROD_WIDTH = 2*DATA_WIDTH;

    state_t state;
    state_t state_n;

    logic [ADDR_WIDTH-1:0]        cnt;
    logic                         pipe;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic [DATA_WIDTH-1:0]        res;

    logic                         clear;
    logic                         last_issue;
    logic signed [PROD_WIDTH-1:0] w_ext;
    logic signed [PROD_WIDTH-1:0] x_ext;
    logic signed [PROD_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]  acc_n;
    logic signed [ACC_WIDTH-1:0]  shifted;
    logic                         pos_ovf;
    logic                         neg_ovf;
    logic [DATA_WIDTH-1:0]        sat;

    // A new evaluation only starts from IDLE; start elsewhere is ignored.
    assign clear      = (state == IDLE) && start;
    assign last_issue = (cnt == LAST_ADDR);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and control outputs.
    always_comb begin
        state_n   = state;
        busy      = 1'b0;
        w_ren     = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = FETCH;
                end
            end
            FETCH: begin
                busy  = 1'b1;
                w_ren = 1'b1;
                if (last_issue) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                busy    = 1'b1;
                state_n = HOLD;
            end
            HOLD: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    done    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Both memories are read in lockstep; addresses are forced to 0 while idle.
    assign x_ren  = w_ren;
    assign w_radd = w_ren ? cnt : '0;
    assign x_radd = w_ren ? cnt : '0;

    // Read address counter: stops at the last address rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if ((state == FETCH) && !last_issue) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Data-valid pipe: memory data returns one cycle after the read enable.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            pipe <= 1'b0;
        end else begin
            pipe <= w_ren;
        end
    end

    // Full-precision signed product, sign-extended into the accumulator width.
    assign w_ext = {{DATA_WIDTH{w_rdata[DATA_WIDTH-1]}}, w_rdata};
    assign x_ext = {{DATA_WIDTH{x_rdata[DATA_WIDTH-1]}}, x_rdata};
    assign prod  = w_ext * x_ext;
    assign acc_n = acc + {{(ACC_WIDTH-PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};

    // Rescale toward -inf, then clamp whenever the bits above the result's sign bit
    // disagree with the accumulator sign.
    assign shifted = acc_n >>> FRAC_BITS;
    assign pos_ovf = !shifted[ACC_WIDTH-1] && (|shifted[ACC_WIDTH-2:DATA_WIDTH-1]);
    assign neg_ovf =  shifted[ACC_WIDTH-1] && !(&shifted[ACC_WIDTH-2:DATA_WIDTH-1]);
    assign sat     = pos_ovf ? {1'b0, {(DATA_WIDTH-1){1'b1}}} :
                     neg_ovf ? {1'b1, {(DATA_WIDTH-1){1'b0}}} :
                     shifted[DATA_WIDTH-1:0];

    // Accumulator and saturated result update together so they always agree.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc <= '0;
            res <= '0;
        end else if (pipe) begin
            acc <= acc_n;
            res <= sat;
        end
    end

    assign acc_out = acc;
    assign res_q   = res;

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// tb/tb_neuron_mac_sequencer.sv - self-checking bench for neuron_mac_sequencer
module tb_neuron_mac_sequencer;

    localparam int NI   = 30;
    localparam int DW   = 16;
    localparam int AW   = 5;
    localparam int FB   = 8;
    localparam int ACCW = 2*DW + 5;
    localparam int NV   = 8;

    typedef struct {
        logic [NI-1:0][DW-1:0] w;
        logic [NI-1:0][DW-1:0] x;
        int                    ready_delay;
        bit                    ignored_start;
        longint                exp_acc;
        logic [DW-1:0]         exp_res;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            busy;
    logic            w_ren;
    logic [AW-1:0]   w_radd;
    logic [DW-1:0]   w_rdata;
    logic            x_ren;
    logic [AW-1:0]   x_radd;
    logic [DW-1:0]   x_rdata;
    logic [ACCW-1:0] acc_out;
    logic [DW-1:0]   res_q;
    logic            out_valid;
    logic            out_ready;
    logic            done;

    logic [NI-1:0][DW-1:0] cur_w;
    logic [NI-1:0][DW-1:0] cur_x;
    vec_t vecs [NV];
    int   tests = 0;
    int   fails = 0;
    int   done_cnt = 0;

    neuron_mac_sequencer #(
        .NUM_INPUTS(NI),
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .FRAC_BITS (FB),
        .ACC_WIDTH (ACCW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .w_ren    (w_ren),
        .w_radd   (w_radd),
        .w_rdata  (w_rdata),
        .x_ren    (x_ren),
        .x_radd   (x_radd),
        .x_rdata  (x_rdata),
        .acc_out  (acc_out),
        .res_q    (res_q),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Synchronous-read memories: data one cycle after the read enable.
    always @(posedge clk) begin
        if (w_ren) w_rdata <= cur_w[w_radd];
        if (x_ren) x_rdata <= cur_x[x_radd];
    end

    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic longint ref_acc(input logic [NI-1:0][DW-1:0] w,
                                       input logic [NI-1:0][DW-1:0] x);
        longint s = 0;
        for (int i = 0; i < NI; i++) begin
            s += longint'($signed(w[i])) * longint'($signed(x[i]));
        end
        return s;
    endfunction

    function automatic logic [DW-1:0] ref_res(input longint a);
        longint q;
        q = a >>> FB;
        if (q > 32767) return 16'h7FFF;
        if (q < -32768) return 16'h8000;
        return q[DW-1:0];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_eval(input int i);
        int errs;
        int d0;
        cur_w     = vecs[i].w;
        cur_x     = vecs[i].x;
        out_ready = (vecs[i].ready_delay == 0);
        d0        = done_cnt;
        start     = 1'b1;
        tick();
        start = 1'b0;
        errs  = 0;
        for (int k = 0; k < NI; k++) begin
            if (!(w_ren && x_ren && busy && !out_valid && !done &&
                  w_radd == AW'(k) && x_radd == AW'(k))) errs++;
            if (vecs[i].ignored_start && k == 5) start = 1'b1;
            tick();
            start = 1'b0;
        end
        check($sformatf("v%0d read_schedule_errors", i), errs, 0);
        check($sformatf("v%0d drain {w_ren,x_ren,out_valid,busy}", i),
              {w_ren, x_ren, out_valid, busy}, 4'b0001);
        check($sformatf("v%0d drain addr", i), {w_radd, x_radd}, 0);
        tick();
        check($sformatf("v%0d out_valid_at_T+32", i), out_valid, 1);
        if (vecs[i].ignored_start) start = 1'b1;
        errs = 0;
        for (int c = 0; c < vecs[i].ready_delay; c++) begin
            if (!(out_valid && busy && !done && !w_ren &&
                  longint'($signed(acc_out)) == vecs[i].exp_acc &&
                  res_q == vecs[i].exp_res)) errs++;
            tick();
        end
        check($sformatf("v%0d backpressure_hold_errors", i), errs, 0);
        out_ready = 1'b1;
        #1;
        check($sformatf("v%0d done_on_handshake", i), {out_valid, done}, 2'b11);
        check($sformatf("v%0d acc_out", i), longint'($signed(acc_out)), vecs[i].exp_acc);
        check($sformatf("v%0d res_q", i), res_q, vecs[i].exp_res);
        @(posedge clk);
        #1;
        start     = 1'b0;
        out_ready = 1'b0;
        check($sformatf("v%0d idle {busy,out_valid,done}", i), {busy, out_valid, done}, 0);
        check($sformatf("v%0d done_pulses", i), done_cnt - d0, 1);
        if (vecs[i].ignored_start) begin
            tick();
            check($sformatf("v%0d no_restart busy", i), busy, 0);
        end
    endtask

    initial begin
        int errs;
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        cur_w     = '0;
        cur_x     = '0;

        for (int i = 0; i < NV; i++) begin
            vecs[i].ready_delay   = 0;
            vecs[i].ignored_start = 1'b0;
            for (int k = 0; k < NI; k++) begin
                case (i)
                    0: begin vecs[i].w[k] = 16'h0100; vecs[i].x[k] = 16'h0100; end
                    1: begin vecs[i].w[k] = (k % 2 == 0) ? 16'h0100 : 16'hFF00; vecs[i].x[k] = 16'h0200; end
                    2: begin vecs[i].w[k] = 16'h7FFF; vecs[i].x[k] = 16'h7FFF; end
                    3: begin vecs[i].w[k] = 16'h8000; vecs[i].x[k] = 16'h7FFF; end
                    4, 5: begin
                        vecs[i].w[k] = DW'($urandom_range(0, 1023) - 512);
                        vecs[i].x[k] = DW'($urandom_range(0, 2047) - 1024);
                    end
                    default: begin
                        vecs[i].w[k] = DW'($urandom);
                        vecs[i].x[k] = DW'($urandom);
                    end
                endcase
            end
        end
        vecs[0].exp_acc = 64'sd1966080;        vecs[0].exp_res = 16'h1E00;
        vecs[1].exp_acc = 64'sd0;              vecs[1].exp_res = 16'h0000;
        vecs[2].exp_acc = 64'sd32210288670;    vecs[2].exp_res = 16'h7FFF;
        vecs[3].exp_acc = -64'sd32211271680;   vecs[3].exp_res = 16'h8000;
        vecs[2].ready_delay   = 10;
        vecs[3].ready_delay   = 3;
        vecs[3].ignored_start = 1'b1;
        for (int i = 4; i < NV; i++) begin
            vecs[i].exp_acc     = ref_acc(vecs[i].w, vecs[i].x);
            vecs[i].exp_res     = ref_res(vecs[i].exp_acc);
            vecs[i].ready_delay = int'($urandom_range(0, 4));
        end
        vecs[6].ignored_start = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        errs = 0;
        for (int c = 0; c < 5; c++) begin
            if ({busy, w_ren, x_ren, out_valid, done} != 0 || w_radd != 0 ||
                x_radd != 0 || acc_out != 0 || res_q != 0) errs++;
            tick();
        end
        check("reset_state_errors", errs, 0);

        for (int i = 0; i < NV; i++) begin
            run_eval(i);
        end

        // Reset while address 12 is being issued discards the partial sum.
        cur_w     = vecs[5].w;
        cur_x     = vecs[5].x;
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        repeat (12) tick();
        check("midreset addr_before", w_radd, 12);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midreset {busy,w_ren,x_ren,out_valid,done}",
              {busy, w_ren, x_ren, out_valid, done}, 0);
        check("midreset addr/acc/res", longint'(w_radd) + longint'(x_radd) +
              longint'(acc_out != 0) + longint'(res_q), 0);
        tick();
        run_eval(7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
